tree_upstream_merger: RTL and testbench



---
 rtl/tree_upstream_merger.sv | 134 +++++++++++++
 tb/tb_tree_upstream_merger.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tree_upstream_merger.sv
// tree_upstream_merger
// Return path from NUM_CHILDREN child ports up to one root port. Each child
// owns a single holding slot; a round-robin arbiter moves one held word per
// cycle into a registered output stage tagged with the child index.
module tree_upstream_merger #(
   parameter int NUM_CHILDREN = 5,
   parameter int DATA_W       = 16,
   parameter int ID_W         = 3,
   parameter int CNT_W        = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_CHILDREN-1:0]        child_valid,
   output logic [NUM_CHILDREN-1:0]        child_ready,
   input  logic [NUM_CHILDREN*DATA_W-1:0] child_data,
   output logic                           up_valid,
   input  logic                           up_ready,
   output logic [DATA_W-1:0]              up_data,
   output logic [ID_W-1:0]                up_id,
   output logic [CNT_W-1:0]               xfer_count,
   output logic                           busy
);

   // Holding slots, one per child
   logic [NUM_CHILDREN-1:0]              r_slot_full;
   logic [NUM_CHILDREN-1:0][DATA_W-1:0]  r_slot_data;

   // Output stage and bookkeeping
   logic                                 r_up_valid;
   logic [DATA_W-1:0]                    r_up_data;
   logic [ID_W-1:0]                      r_up_id;
   logic [ID_W-1:0]                      r_last_grant;
   logic [CNT_W-1:0]                     r_xfer_count;

   // Arbiter results
   logic                                 w_can_load;
   logic                                 w_grant_found;
   logic                                 w_load;
   logic [NUM_CHILDREN-1:0]              w_grant_oh;
   logic [ID_W-1:0]                      w_grant_idx;
   logic [DATA_W-1:0]                    w_grant_data;
   logic [NUM_CHILDREN-1:0]              w_capture;

   // The output stage can take a new word when it is empty or being drained
   assign w_can_load = ~r_up_valid | up_ready;
   assign w_load     = w_can_load & w_grant_found;

   // Round-robin pick: the full slot with the smallest distance past last_grant wins
   always_comb begin
      int v_dist;
      int v_best;
      v_dist        = 0;
      v_best        = NUM_CHILDREN;
      w_grant_found = 1'b0;
      w_grant_oh    = '0;
      w_grant_idx   = '0;
      w_grant_data  = '0;
      for (int i = 0; i < NUM_CHILDREN; i++) begin
         // last_grant never exceeds NUM_CHILDREN-1, so the sum stays non-negative
         v_dist = (i + NUM_CHILDREN - 1 - int'(r_last_grant)) % NUM_CHILDREN;
         if (r_slot_full[i] && (v_dist < v_best)) begin
            v_best        = v_dist;
            w_grant_found = 1'b1;
            w_grant_oh    = '0;
            w_grant_oh[i] = 1'b1;
            w_grant_idx   = ID_W'(i);
            w_grant_data  = r_slot_data[i];
         end else begin
            v_best        = v_best;
         end
      end
   end

   // A slot accepts only when empty, so capture and grant never hit the same slot
   assign w_capture = child_valid & ~r_slot_full;

   // Slot fill on child handshake, drain on grant
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_slot_full <= '0;
         r_slot_data <= '0;
      end else begin
         for (int i = 0; i < NUM_CHILDREN; i++) begin
            if (w_capture[i]) begin
               r_slot_full[i] <= 1'b1;
               r_slot_data[i] <= child_data[i*DATA_W +: DATA_W];
            end else if (w_load && w_grant_oh[i]) begin
               r_slot_full[i] <= 1'b0;
            end else begin
               r_slot_full[i] <= r_slot_full[i];
            end
         end
      end
   end

   // Registered upstream stage: load winner, drop valid when drained, else hold
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_up_valid   <= 1'b0;
         r_up_data    <= '0;
         r_up_id      <= '0;
         r_last_grant <= ID_W'(NUM_CHILDREN - 1);
      end else if (w_load) begin
         r_up_valid   <= 1'b1;
         r_up_data    <= w_grant_data;
         r_up_id      <= w_grant_idx;
         r_last_grant <= w_grant_idx;
      end else if (up_ready) begin
         r_up_valid   <= 1'b0;
      end else begin
         r_up_valid   <= r_up_valid;
      end
   end

   // Count completed upstream transfers, wrapping naturally
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_xfer_count <= '0;
      end else if (r_up_valid && up_ready) begin
         r_xfer_count <= r_xfer_count + CNT_W'(1);
      end else begin
         r_xfer_count <= r_xfer_count;
      end
   end

   // All outputs are decoded from registers only
   assign child_ready = ~r_slot_full;
   assign up_valid    = r_up_valid;
   assign up_data     = r_up_data;
   assign up_id       = r_up_id;
   assign xfer_count  = r_xfer_count;
   assign busy        = (|r_slot_full) | r_up_valid;

endmodule

// File: tb/tb_tree_upstream_merger.sv
// tb_tree_upstream_merger
// Directed vectors with hand-computed expectations plus a random
// loss/duplication scoreboard. A second instance with a 4-bit counter
// shares the stimulus to exercise counter wrap.
module tb_tree_upstream_merger;
   localparam int N  = 5;
   localparam int DW = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    child_valid;
   logic [N*DW-1:0] child_data;
   logic            up_ready;

   logic [N-1:0]    child_ready;
   logic            up_valid;
   logic [DW-1:0]   up_data;
   logic [2:0]      up_id;
   logic [15:0]     xfer_count;
   logic            busy;

   logic [N-1:0]    w_child_ready;
   logic            w_up_valid;
   logic [DW-1:0]   w_up_data;
   logic [2:0]      w_up_id;
   logic [3:0]      w_xfer_count;
   logic            w_busy;

   int n_cmp = 0;
   int n_err = 0;
   int n_out = 0;
   int done;
   logic [15:0] sb_q [N][$];

   always #5 clk = ~clk;

   tree_upstream_merger #(.NUM_CHILDREN(N), .DATA_W(DW), .ID_W(3), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .child_valid(child_valid), .child_ready(child_ready),
      .child_data(child_data), .up_valid(up_valid), .up_ready(up_ready),
      .up_data(up_data), .up_id(up_id), .xfer_count(xfer_count), .busy(busy));

   tree_upstream_merger #(.NUM_CHILDREN(N), .DATA_W(DW), .ID_W(3), .CNT_W(4)) dut_w (
      .clk(clk), .rst(rst), .child_valid(child_valid), .child_ready(w_child_ready),
      .child_data(child_data), .up_valid(w_up_valid), .up_ready(up_ready),
      .up_data(w_up_data), .up_id(w_up_id), .xfer_count(w_xfer_count), .busy(w_busy));

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int i, input logic [15:0] d);
      child_valid[i]          = 1'b1;
      child_data[i*DW +: DW]  = d;
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      child_valid = '0;
      up_ready    = 1'b0;
      tick();
      rst         = 1'b0;
   endtask

   // Record child handshakes and check upstream words against per-child queues
   task automatic sb_observe();
      int id;
      for (int i = 0; i < N; i++) begin
         if (child_valid[i] && child_ready[i]) sb_q[i].push_back(child_data[i*DW +: DW]);
      end
      if (up_valid && up_ready) begin
         id = int'(up_id);
         check_eq("sb_id_range", 32'(id < N), 32'd1);
         if (id < N) begin
            check_eq("sb_avail", 32'(sb_q[id].size() > 0), 32'd1);
            if (sb_q[id].size() > 0) check_eq("sb_data", 32'(up_data), 32'(sb_q[id].pop_front()));
         end
         n_out++;
      end
   endtask

   initial begin
      rst         = 1'b1;
      child_valid = '0;
      child_data  = '0;
      up_ready    = 1'b0;
      #3;
      check_eq("rst_up_valid", 32'(up_valid), 32'd0);
      check_eq("rst_up_data", 32'(up_data), 32'd0);
      check_eq("rst_up_id", 32'(up_id), 32'd0);
      check_eq("rst_xfer", 32'(xfer_count), 32'd0);
      check_eq("rst_ready", 32'(child_ready), 32'h1F);
      check_eq("rst_busy", 32'(busy), 32'd0);
      tick();
      rst = 1'b0;

      // Single child
      up_ready = 1'b1;
      send(2, 16'hA5A5);
      tick();
      child_valid = '0;
      check_eq("single_ready_low", 32'(child_ready), 32'h1B);
      check_eq("single_busy", 32'(busy), 32'd1);
      check_eq("single_no_valid_yet", 32'(up_valid), 32'd0);
      tick();
      check_eq("single_valid", 32'(up_valid), 32'd1);
      check_eq("single_data", 32'(up_data), 32'hA5A5);
      check_eq("single_id", 32'(up_id), 32'd2);
      tick();
      check_eq("single_xfer", 32'(xfer_count), 32'd1);
      check_eq("single_valid_drop", 32'(up_valid), 32'd0);
      check_eq("single_data_hold", 32'(up_data), 32'hA5A5);
      check_eq("single_idle", 32'(busy), 32'd0);

      // Fairness with continuous refill, and counter wrap on the 4-bit instance
      do_reset();
      up_ready = 1'b1;
      for (int i = 0; i < N; i++) send(i, 16'(16'h0010 + i));
      for (int e = 1; e <= 19; e++) begin
         tick();
         if (e == 1) begin
            check_eq("fair_all_captured", 32'(child_ready), 32'd0);
            check_eq("fair_first_empty", 32'(up_valid), 32'd0);
         end else begin
            check_eq("fair_valid", 32'(up_valid), 32'd1);
            check_eq("fair_id", 32'(up_id), 32'((e - 2) % N));
            check_eq("fair_data", 32'(up_data), 32'(16'h0010 + (e - 2) % N));
         end
         if (e == 17) check_eq("wrap_15", 32'(w_xfer_count), 32'd15);
         if (e == 18) check_eq("wrap_0", 32'(w_xfer_count), 32'd0);
         if (e == 19) begin
            check_eq("wrap_1", 32'(w_xfer_count), 32'd1);
            check_eq("fair_xfer17", 32'(xfer_count), 32'd17);
         end
      end
      child_valid = '0;
      done = 0;
      for (int c = 0; c < 20 && done == 0; c++) begin
         tick();
         if (!busy) done = 1;
      end
      check_eq("fair_drain_done", 32'(done), 32'd1);

      // Backpressure
      do_reset();
      send(1, 16'h0101);
      send(3, 16'h0303);
      send(4, 16'h0404);
      tick();
      child_valid = '0;
      tick();
      check_eq("bp_first_id", 32'(up_id), 32'd1);
      for (int c = 0; c < 6; c++) begin
         tick();
         check_eq("bp_valid_hold", 32'(up_valid), 32'd1);
         check_eq("bp_data_hold", 32'(up_data), 32'h0101);
         check_eq("bp_id_hold", 32'(up_id), 32'd1);
         check_eq("bp_ready", 32'(child_ready), 32'h07);
      end
      up_ready = 1'b1;
      tick();
      check_eq("bp_drain_id3", 32'(up_id), 32'd3);
      check_eq("bp_drain_d3", 32'(up_data), 32'h0303);
      tick();
      check_eq("bp_drain_id4", 32'(up_id), 32'd4);
      check_eq("bp_drain_d4", 32'(up_data), 32'h0404);
      tick();
      check_eq("bp_empty", 32'(up_valid), 32'd0);
      check_eq("bp_xfer", 32'(xfer_count), 32'd3);

      // Reset mid-operation
      up_ready = 1'b0;
      send(0, 16'h0A00);
      send(2, 16'h0A02);
      send(3, 16'h0A03);
      tick();
      child_valid = '0;
      tick();
      check_eq("mid_grant0", 32'(up_id), 32'd0);
      send(0, 16'h0B00);
      tick();
      child_valid = '0;
      check_eq("mid_three_full", 32'(child_ready), 32'h12);
      check_eq("mid_valid_before", 32'(up_valid), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check_eq("mid_rst_valid", 32'(up_valid), 32'd0);
      check_eq("mid_rst_data", 32'(up_data), 32'd0);
      check_eq("mid_rst_ready", 32'(child_ready), 32'h1F);
      check_eq("mid_rst_busy", 32'(busy), 32'd0);
      check_eq("mid_rst_xfer", 32'(xfer_count), 32'd0);
      tick();
      rst      = 1'b0;
      up_ready = 1'b1;
      send(3, 16'h0C03);
      send(0, 16'h0C00);
      tick();
      child_valid = '0;
      tick();
      check_eq("mid_after_id0", 32'(up_id), 32'd0);
      check_eq("mid_after_d0", 32'(up_data), 32'h0C00);
      tick();
      check_eq("mid_after_id3", 32'(up_id), 32'd3);

      // Refill of one slot on the edge another slot is granted
      do_reset();
      up_ready = 1'b1;
      send(1, 16'h1111);
      send(3, 16'h3333);
      tick();
      child_valid = '0;
      tick();
      check_eq("il_id1", 32'(up_id), 32'd1);
      send(1, 16'h1112);
      tick();
      child_valid = '0;
      check_eq("il_id3", 32'(up_id), 32'd3);
      check_eq("il_d3", 32'(up_data), 32'h3333);
      check_eq("il_ready", 32'(child_ready), 32'h1D);
      tick();
      check_eq("il_id1_again", 32'(up_id), 32'd1);
      check_eq("il_d1_again", 32'(up_data), 32'h1112);
      tick();
      check_eq("il_xfer", 32'(xfer_count), 32'd3);

      // Random scoreboard run
      do_reset();
      n_out = 0;
      for (int c = 0; c < 1000; c++) begin
         child_valid = N'($urandom_range(0, 31));
         for (int i = 0; i < N; i++) child_data[i*DW +: DW] = 16'($urandom);
         up_ready = ($urandom_range(0, 3) != 0);
         sb_observe();
         tick();
      end
      child_valid = '0;
      up_ready    = 1'b1;
      for (int c = 0; c < 40; c++) begin
         sb_observe();
         tick();
      end
      done = 0;
      for (int i = 0; i < N; i++) done += sb_q[i].size();
      check_eq("sb_all_drained", 32'(done), 32'd0);
      check_eq("sb_idle", 32'(busy), 32'd0);
      check_eq("sb_xfer_count", 32'(xfer_count), 32'(16'(n_out)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
